// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared definitions for the instruction fetch front end:
//                fetch FSM state encoding, instruction field slice positions,
//                default reset PC and a branch-offset helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Fetch sequencing states
    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECODE = 2'd2,
        ST_HALT   = 2'd3
    } fetch_state_t;

    // Instruction field positions
    localparam int c_OP_HI    = 31;
    localparam int c_OP_LO    = 26;
    localparam int c_FUNCT_HI = 5;
    localparam int c_FUNCT_LO = 0;

    localparam logic [31:0] c_DEFAULT_RESET_PC = 32'h0000_0000;

    // Sign-extended, word-scaled branch displacement
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_next_logic.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_logic
//  Description : Combinational redirect target selection for the fetch unit.
//                Priority jr > jump > taken branch. When no redirect is
//                taken, the caller falls through to pc_plus4.
//  Ports       : pc_plus4   in  32  sequential successor of the held PC
//                instr_low  in  26  instr[25:0] of the held instruction
//                branch     in   1  decoder Branch
//                zero       in   1  ALU zero (branch taken = branch & zero)
//                jump       in   1  decoder Jump
//                jr         in   1  decoder Jr
//                jr_target  in  32  rs value for jr
//                taken      out  1  some redirect is active
//                target     out 32  redirect destination
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_next_logic
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr_low,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        taken,
    output logic [31:0] target
);

    logic [31:0] w_jr_tgt;
    logic [31:0] w_jump_tgt;
    logic [31:0] w_branch_tgt;

    // Register targets are always word aligned; low bits are discarded.
    assign w_jr_tgt     = jr_target & ~32'h0000_0003;
    assign w_jump_tgt   = {pc_plus4[31:28], instr_low, 2'b00};
    assign w_branch_tgt = pc_plus4 + branch_offset(instr_low[15:0]);

    always_comb begin
        taken  = 1'b0;
        target = pc_plus4;
        if (jr) begin
            taken  = 1'b1;
            target = w_jr_tgt;
        end else if (jump) begin
            taken  = 1'b1;
            target = w_jump_tgt;
        end else if (branch && zero) begin
            taken  = 1'b1;
            target = w_branch_tgt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Owns the PC, fetches one instruction per pass from
//                instruction memory into the IF/ID register, presents op/funct
//                to the decoder and applies Branch/Jump/Jr redirects.
//                Serialized: fetch -> decode-hold -> advance.
//  Build macro : DELAY_SLOT_EN - one architectural delay slot after a taken
//                redirect; link_addr becomes pc + 8.
//  Parameters  : RESET_PC       PC loaded on reset
//                TIMEOUT_CYCLES max imem wait cycles before fetch_err (1..65535)
//  Ports       : clk, rst_n (async active-low)
//                imem_req/imem_addr/imem_ready/imem_rdata  instruction memory
//                stall                                     hazard hold in DECODE
//                branch/zero/jump/jr/jr_target             redirect controls
//                instr/op/funct/instr_valid                IF/ID contents
//                pc/pc_plus4/link_addr                     address outputs
//                fetch_err                                 sticky imem timeout
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = c_DEFAULT_RESET_PC,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] link_addr,
    output logic        fetch_err
);

    localparam logic [15:0] c_COUNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic         r_instr_valid;
    logic         r_imem_req;
    logic         r_fetch_err;
    logic [15:0]  r_count;

`ifdef DELAY_SLOT_EN
    logic [31:0]  r_pending_pc;
    logic         r_in_slot;
`endif

    logic [31:0]  w_pc_plus4;
    logic         w_taken;
    logic [31:0]  w_target;
    logic [31:0]  w_next_pc;

    assign w_pc_plus4 = r_pc + 32'd4;

    pc_next_logic u_pc_next_logic (
        .pc_plus4  (w_pc_plus4),
        .instr_low (r_instr[25:0]),
        .branch    (branch),
        .zero      (zero),
        .jump      (jump),
        .jr        (jr),
        .jr_target (jr_target),
        .taken     (w_taken),
        .target    (w_target)
    );

    assign w_next_pc = w_taken ? w_target : w_pc_plus4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_PC;
            r_instr       <= 32'd0;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b0;
            r_fetch_err   <= 1'b0;
            r_count       <= 16'd0;
`ifdef DELAY_SLOT_EN
            r_pending_pc  <= 32'd0;
            r_in_slot     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_imem_req <= 1'b1;
                    r_state    <= ST_FETCH;
                end

                // stall has no effect while waiting on memory
                ST_FETCH: begin
                    if (imem_ready) begin
                        r_instr       <= imem_rdata;
                        r_instr_valid <= 1'b1;
                        r_count       <= 16'd0;
                        r_imem_req    <= 1'b0;
                        r_state       <= ST_DECODE;
                    end else if (r_count == c_COUNT_LAST) begin
                        r_fetch_err   <= 1'b1;
                        r_imem_req    <= 1'b0;
                        r_state       <= ST_HALT;
                    end else begin
                        r_count       <= r_count + 16'd1;
                    end
                end

                ST_DECODE: begin
                    if (!stall) begin
`ifdef DELAY_SLOT_EN
                        // A redirect seen inside the delay slot is dropped;
                        // the slot always resumes at the saved target.
                        if (r_in_slot) begin
                            r_pc      <= r_pending_pc;
                            r_in_slot <= 1'b0;
                        end else if (w_taken) begin
                            r_pending_pc <= w_target;
                            r_in_slot    <= 1'b1;
                            r_pc         <= w_pc_plus4;
                        end else begin
                            r_pc <= w_pc_plus4;
                        end
`else
                        r_pc <= w_next_pc;
`endif
                        r_instr_valid <= 1'b0;
                        r_imem_req    <= 1'b1;
                        r_state       <= ST_FETCH;
                    end
                end

                ST_HALT: begin
                    r_instr_valid <= 1'b0;
                    r_imem_req    <= 1'b0;
                end

                default: begin
                    r_instr_valid <= 1'b0;
                    r_imem_req    <= 1'b0;
                    r_state       <= ST_HALT;
                end
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign op          = r_instr[c_OP_HI:c_OP_LO];
    assign funct       = r_instr[c_FUNCT_HI:c_FUNCT_LO];
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign fetch_err   = r_fetch_err;

`ifdef DELAY_SLOT_EN
    // Return past the delay slot
    assign link_addr   = r_pc + 32'd8;
    logic w_unused_next;
    assign w_unused_next = |w_next_pc;
`else
    assign link_addr   = w_pc_plus4;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit. Directed scenarios
//                followed by randomized fetch/decode passes checked against a
//                behavioural PC model. Honours DELAY_SLOT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int          c_TIMEOUT  = 4;
    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch;
    logic        zero;
    logic        jump;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] link_addr;
    logic        fetch_err;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC       (c_RESET_PC),
        .TIMEOUT_CYCLES (c_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .branch      (branch),
        .zero        (zero),
        .jump        (jump),
        .jr          (jr),
        .jr_target   (jr_target),
        .instr       (instr),
        .op          (op),
        .funct       (funct),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .link_addr   (link_addr),
        .fetch_err   (fetch_err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pend;
    bit          m_slot;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = c_RESET_PC;
        m_instr = 32'd0;
        m_pend  = 32'd0;
        m_slot  = 1'b0;
    endtask

    // Redirect resolution from the architectural rules
    task automatic model_advance(input bit br, input bit z, input bit jp, input bit jri,
                                 input logic [31:0] jt);
        logic [31:0] seq;
        logic [31:0] tgt;
        bit          tk;
        int          disp;
        seq  = m_pc + 32'd4;
        disp = int'($signed(m_instr[15:0])) * 4;
        tk   = 1'b1;
        if (jri)           tgt = jt - (jt % 4);
        else if (jp)       tgt = (seq & 32'hF000_0000) + ({6'd0, m_instr[25:0]} * 4);
        else if (br && z)  tgt = seq + 32'(disp);
        else begin         tgt = seq; tk = 1'b0; end
`ifdef DELAY_SLOT_EN
        if (m_slot) begin
            m_pc   = m_pend;
            m_slot = 1'b0;
        end else if (tk) begin
            m_pend = tgt;
            m_slot = 1'b1;
            m_pc   = seq;
        end else begin
            m_pc   = seq;
        end
`else
        m_pc = tk ? tgt : seq;
`endif
    endtask

    function automatic logic [31:0] exp_link(input logic [31:0] a);
`ifdef DELAY_SLOT_EN
        return a + 32'd8;
`else
        return a + 32'd4;
`endif
    endfunction

    // Entered at a negedge with the DUT in FETCH; leaves at a negedge in DECODE
    task automatic do_fetch(input logic [31:0] word, input int waits);
        for (int i = 0; i < waits; i++) begin
            chk("fetch_req", {31'd0, imem_req}, 32'd1);
            chk("fetch_addr", imem_addr, m_pc);
            stall = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, m_pc);
        chk("fetch_valid_low", {31'd0, instr_valid}, 32'd0);
        imem_ready = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        stall      = 1'b0;
        m_instr    = word;
        chk("dec_instr", instr, m_instr);
        chk("dec_op", {26'd0, op}, {26'd0, m_instr[31:26]});
        chk("dec_funct", {26'd0, funct}, {26'd0, m_instr[5:0]});
        chk("dec_valid", {31'd0, instr_valid}, 32'd1);
        chk("dec_pc", pc, m_pc);
        chk("dec_pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("dec_link", link_addr, exp_link(m_pc));
        chk("dec_req_low", {31'd0, imem_req}, 32'd0);
    endtask

    // Entered at a negedge in DECODE; leaves at a negedge in FETCH
    task automatic do_decode(input bit br, input bit z, input bit jp, input bit jri,
                             input logic [31:0] jt, input int nstall);
        for (int i = 0; i < nstall; i++) begin
            stall     = 1'b1;
            branch    = 1'($urandom);
            zero      = 1'($urandom);
            jump      = 1'($urandom);
            jr        = 1'($urandom);
            jr_target = $urandom;
            @(negedge clk);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_instr", instr, m_instr);
            chk("stall_pc", pc, m_pc);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
        end
        stall     = 1'b0;
        branch    = br;
        zero      = z;
        jump      = jp;
        jr        = jri;
        jr_target = jt;
        @(negedge clk);
        branch    = 1'b0;
        zero      = 1'b0;
        jump      = 1'b0;
        jr        = 1'b0;
        jr_target = 32'd0;
        model_advance(br, z, jp, jri, jt);
        chk("adv_valid_low", {31'd0, instr_valid}, 32'd0);
        chk("adv_pc", pc, m_pc);
    endtask

    task automatic step(input logic [31:0] word, input bit br, input bit z, input bit jp,
                        input bit jri, input logic [31:0] jt, input int nstall);
        do_fetch(word, 0);
        do_decode(br, z, jp, jri, jt, nstall);
    endtask

    initial begin
        rst_n      = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'd0;
        stall      = 1'b0;
        branch     = 1'b0;
        zero       = 1'b0;
        jump       = 1'b0;
        jr         = 1'b0;
        jr_target  = 32'd0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);
        chk("rst_pc", pc, c_RESET_PC);
        chk("rst_instr", instr, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);  // BOOT -> FETCH on this edge

        // addi at 0, ready on the second FETCH cycle
        do_fetch(32'h2008_0005, 1);
        chk("addi_op", {26'd0, op}, 32'd8);
        do_decode(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 0);
        chk("seq_addr4", imem_addr, 32'd4);

        // 4 -> 8, then not-taken branch at 8 -> 0xC
        step(32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 0);
        step(32'h1000_0003, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 0);
        chk("bnt_addr", imem_addr, 32'h0000_000C);

        // j back to 8 and take the branch
        step(32'h0800_0002, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 0);
`ifdef DELAY_SLOT_EN
        step(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 0);
`endif
        step(32'h1000_0003, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 0);
`ifdef DELAY_SLOT_EN
        chk("bt_slot_addr", imem_addr, 32'h0000_000C);
        step(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 0);
`endif
        chk("bt_addr", imem_addr, 32'h0000_0018);

        // j 0x40, then jal 0x40 from 0x40
        step(32'h0800_0010, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 0);
`ifdef DELAY_SLOT_EN
        step(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 0);
`endif
        chk("jal_pc", imem_addr, 32'h0000_0040);
        do_fetch(32'h0C00_0010, 0);
`ifdef DELAY_SLOT_EN
        chk("jal_link", link_addr, 32'h0000_0048);
`else
        chk("jal_link", link_addr, 32'h0000_0044);
`endif
        do_decode(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 0);
`ifdef DELAY_SLOT_EN
        chk("jal_slot_addr", imem_addr, 32'h0000_0044);
        step(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 0);
`endif
        chk("jal_addr", imem_addr, 32'h0000_0040);

        // jr wins over jump, target low bits dropped
        step(32'h0800_0200, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0103, 0);
`ifdef DELAY_SLOT_EN
        step(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 0);
`endif
        chk("jr_addr", imem_addr, 32'h0000_0100);

        // Three stall cycles in DECODE, then release
        step(32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 3);
        chk("stall_adv_addr", imem_addr, 32'h0000_0104);

        // Wraparound of the sequential path
        step(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 0);
`ifdef DELAY_SLOT_EN
        step(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 0);
`endif
        do_fetch(32'h0000_0000, 0);
        chk("wrap_plus4", pc_plus4, 32'd0);
        do_decode(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 0);
        chk("wrap_addr", imem_addr, 32'd0);

        // Randomized passes; waits up to TIMEOUT-1 exercise the last-cycle ready
        for (int n = 0; n < 30; n++) begin
            do_fetch($urandom, $urandom_range(0, c_TIMEOUT - 1));
            do_decode(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 2));
        end

        // Timeout: no ready for TIMEOUT cycles
        chk("to_err_before", {31'd0, fetch_err}, 32'd0);
        for (int i = 0; i < c_TIMEOUT; i++) begin
            chk("to_req", {31'd0, imem_req}, 32'd1);
            @(negedge clk);
        end
        chk("to_err", {31'd0, fetch_err}, 32'd1);
        chk("to_req_low", {31'd0, imem_req}, 32'd0);
        chk("to_valid_low", {31'd0, instr_valid}, 32'd0);
        imem_ready = 1'b1;
        repeat (3) @(negedge clk);
        imem_ready = 1'b0;
        chk("halt_err", {31'd0, fetch_err}, 32'd1);
        chk("halt_req", {31'd0, imem_req}, 32'd0);
        chk("halt_valid", {31'd0, instr_valid}, 32'd0);

        // Async reset out of HALT
        rst_n = 1'b0;
        #1;
        chk("rst_halt_err", {31'd0, fetch_err}, 32'd0);
        chk("rst_halt_req", {31'd0, imem_req}, 32'd0);
        chk("rst_halt_pc", pc, c_RESET_PC);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("rst2_req", {31'd0, imem_req}, 32'd1);
        @(negedge clk);

        // Reset in the middle of a memory wait
        #2;
        rst_n = 1'b0;
        #1;
        chk("midwait_req", {31'd0, imem_req}, 32'd0);
        chk("midwait_err", {31'd0, fetch_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        step(32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 0);
        chk("recover_addr", imem_addr, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute safety net against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
